battery_fan_scheduler: RTL and testbench

- Owns the battery-level register and grants the fan gear.
- Sequences discharge and charge on a 1 s tick and forces the fan off when the battery is depleted.
- Drives `battery`, `charging` and `fan_state` into the LED controller and the motor PWM stage, in the 1000 Hz clk domain.

---
 rtl/battery_fan_scheduler_pkg.sv | 30 +++
 rtl/battery_fan_scheduler_tick_gen.sv | 30 +++
 rtl/battery_fan_scheduler.sv | 106 ++++++++++
 tb/tb_battery_fan_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/battery_fan_scheduler_pkg.sv
// Shared definitions for the battery/fan scheduler and its consumers (LED controller, PWM stage).
// Holds the state encodings, gear codes, level defaults and saturating arithmetic helpers.
package battery_fan_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_CHARGE   = 2'd1,
        ST_DEPLETED = 2'd2
    } sched_state_e;

    localparam logic [1:0] GEAR_OFF = 2'd0;
    localparam logic [1:0] GEAR_1   = 2'd1;
    localparam logic [1:0] GEAR_2   = 2'd2;
    localparam logic [1:0] GEAR_3   = 2'd3;

    localparam int unsigned BATT_MAX_DEF  = 99;
    localparam int unsigned LOW_LEVEL_DEF = 25;

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] lim);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[7:0];
    endfunction

endpackage

// File: rtl/battery_fan_scheduler_tick_gen.sv
// Free-running divider producing a one-cycle scheduler tick every TICK_DIV clocks.
// Only reset clears the counter; scheduler state changes never restart it.
module tick_gen
    import battery_fan_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/battery_fan_scheduler.sv
// Battery-level owner and fan-gear arbiter: drains on tick in NORMAL, charges in CHARGE,
// and forces the fan off in DEPLETED until the key is released at a safe level (rearm).
module battery_fan_scheduler
    import battery_fan_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned BATT_MAX     = BATT_MAX_DEF,
    parameter int unsigned BATT_INIT    = 99,
    parameter int unsigned CHARGE_STEP  = 2,
    parameter int unsigned LOW_LEVEL    = LOW_LEVEL_DEF,
    parameter int unsigned RESUME_LEVEL = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] fan_req,
    input  logic       charger_in,
    output logic [7:0] battery,
    output logic       charging,
    output logic [1:0] fan_state,
    output logic       low_batt,
    output logic       full,
    output logic       depleted
);

    localparam logic [7:0] MAX8    = 8'(BATT_MAX);
    localparam logic [7:0] INIT8   = 8'(BATT_INIT);
    localparam logic [7:0] STEP8   = 8'(CHARGE_STEP);
    localparam logic [7:0] LOW8    = 8'(LOW_LEVEL);
    localparam logic [7:0] RESUME8 = 8'(RESUME_LEVEL);

    logic         tick;
    sched_state_e state_q, state_d;
    logic [7:0]   battery_q, battery_d;
    logic [1:0]   fan_q, fan_d;
    logic         rearm_q, rearm_d;
    logic         charging_q, depleted_q, low_q, full_q;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        battery_d = battery_q;
        fan_d     = fan_req;
        rearm_d   = rearm_q;

        // Tick arithmetic follows the current state even when a transition happens this cycle
        case (state_q)
            ST_NORMAL: begin
                if (tick) battery_d = sat_sub(battery_q, {6'd0, fan_q});
                if (charger_in)            state_d = ST_CHARGE;
                else if (battery_d == '0)  state_d = ST_DEPLETED;
            end
            ST_CHARGE: begin
                if (tick) battery_d = sat_add(battery_q, STEP8, MAX8);
                if (!charger_in) state_d = (battery_d != '0) ? ST_NORMAL : ST_DEPLETED;
            end
            ST_DEPLETED: begin
                battery_d = '0;
                if (charger_in) state_d = ST_CHARGE;
            end
            default: state_d = ST_NORMAL;
        endcase

        if (state_d == ST_DEPLETED) begin
            fan_d   = GEAR_OFF;
            rearm_d = 1'b1;
        end else if (rearm_q) begin
            fan_d = GEAR_OFF;
            if (fan_req == GEAR_OFF && battery_q >= RESUME8) rearm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_NORMAL;
            battery_q  <= INIT8;
            fan_q      <= GEAR_OFF;
            rearm_q    <= 1'b0;
            charging_q <= 1'b0;
            depleted_q <= 1'b0;
            low_q      <= (INIT8 <= LOW8);
            full_q     <= (INIT8 == MAX8);
        end else begin
            state_q    <= state_d;
            battery_q  <= battery_d;
            fan_q      <= fan_d;
            rearm_q    <= rearm_d;
            charging_q <= (state_d == ST_CHARGE);
            depleted_q <= (state_d == ST_DEPLETED);
            low_q      <= (battery_d <= LOW8);
            full_q     <= (battery_d == MAX8);
        end
    end

    assign battery   = battery_q;
    assign charging  = charging_q;
    assign fan_state = fan_q;
    assign low_batt  = low_q;
    assign full      = full_q;
    assign depleted  = depleted_q;

endmodule

// File: tb/tb_battery_fan_scheduler.sv
// Bench for battery_fan_scheduler: directed scenarios plus random stimulus against a
// cycle-level reference model of the scheduling rules.
module tb_battery_fan_scheduler;

    localparam int TD   = 4;
    localparam int MAXL = 99;
    localparam int INIT = 99;
    localparam int STEP = 2;
    localparam int LOWL = 25;
    localparam int RES  = 10;

    localparam int MODE_RUN = 0;
    localparam int MODE_CHG = 1;
    localparam int MODE_DEP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] fan_req = 2'd0;
    logic       charger_in = 1'b0;
    logic [7:0] battery;
    logic       charging;
    logic [1:0] fan_state;
    logic       low_batt;
    logic       full;
    logic       depleted;

    int n_vec = 0;
    int n_err = 0;

    int m_mode, m_batt, m_fan, m_cnt, m_prev_mode;
    bit m_rearm, m_last_tick;

    battery_fan_scheduler #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fan_req   (fan_req),
        .charger_in(charger_in),
        .battery   (battery),
        .charging  (charging),
        .fan_state (fan_state),
        .low_batt  (low_batt),
        .full      (full),
        .depleted  (depleted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = MODE_RUN;
        m_batt  = INIT;
        m_fan   = 0;
        m_rearm = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input int req, input bit chg);
        int nb;
        int nm;
        bit tk;
        tk = (m_cnt == TD - 1);
        m_cnt = (m_cnt + 1) % TD;
        m_last_tick = tk;
        m_prev_mode = m_mode;
        nb = m_batt;
        nm = m_mode;
        if (m_mode == MODE_RUN) begin
            if (tk) nb = (m_batt > m_fan) ? m_batt - m_fan : 0;
            if (chg) nm = MODE_CHG;
            else if (nb == 0) nm = MODE_DEP;
        end else if (m_mode == MODE_CHG) begin
            if (tk) nb = (m_batt + STEP > MAXL) ? MAXL : m_batt + STEP;
            if (!chg) nm = (nb > 0) ? MODE_RUN : MODE_DEP;
        end else begin
            nb = 0;
            if (chg) nm = MODE_CHG;
        end
        if (nm == MODE_DEP) begin
            m_fan = 0;
            m_rearm = 1'b1;
        end else if (m_rearm) begin
            m_fan = 0;
            if (req == 0 && m_batt >= RES) m_rearm = 1'b0;
        end else begin
            m_fan = req;
        end
        m_batt = nb;
        m_mode = nm;
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, ".battery"},  int'(battery),   m_batt);
        check_eq({ph, ".charging"}, int'(charging),  int'(m_mode == MODE_CHG));
        check_eq({ph, ".fan"},      int'(fan_state), m_fan);
        check_eq({ph, ".low"},      int'(low_batt),  int'(m_batt <= LOWL));
        check_eq({ph, ".full"},     int'(full),      int'(m_batt == MAXL));
        check_eq({ph, ".depleted"}, int'(depleted),  int'(m_mode == MODE_DEP));
    endtask

    // Entered and left at a falling edge.
    task automatic run_cycle(input int req, input bit chg, input string ph);
        fan_req = 2'(req);
        charger_in = chg;
        model_step(req, chg);
        @(posedge clk);
        #1;
        check_outputs(ph);
        @(negedge clk);
    endtask

    initial begin
        int ticks;
        int req;
        bit chg;
        bit done;

        model_reset();
        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // Gear 3 from full: first tick on the 4th cycle, 10 ticks reach 69
        for (int i = 0; i < 3; i++) run_cycle(3, 1'b0, "drain3");
        check_eq("pre_first_tick", int'(battery), 99);
        run_cycle(3, 1'b0, "drain3");
        check_eq("first_tick", int'(battery), 96);
        for (int i = 4; i < 40; i++) run_cycle(3, 1'b0, "drain3");
        check_eq("ten_ticks", int'(battery), 69);
        check_eq("ten_ticks_low", int'(low_batt), 0);

        // Walk down to 2, then gear 3 saturates at 0 and depletes
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            req = (m_batt > 5) ? 3 : ((m_batt > 2) ? 1 : 3);
            run_cycle(req, 1'b0, "to_dep");
            done = (m_mode == MODE_DEP);
        end
        check_eq("dep_flag", int'(depleted), 1);
        check_eq("dep_batt", int'(battery), 0);
        check_eq("dep_fan", int'(fan_state), 0);

        // Charge from depletion with the key held: fan stays off until released
        ticks = 0;
        for (int i = 0; i < 200 && ticks < 6; i++) begin
            run_cycle(2, 1'b1, "chg_held");
            if (m_last_tick && m_prev_mode == MODE_CHG) ticks++;
        end
        check_eq("chg6_batt", int'(battery), 12);
        check_eq("chg6_charging", int'(charging), 1);
        check_eq("chg6_fan", int'(fan_state), 0);
        run_cycle(0, 1'b1, "rearm_rel");
        check_eq("rearm_rel_fan", int'(fan_state), 0);
        run_cycle(2, 1'b1, "rearm_req");
        check_eq("rearm_regrant", int'(fan_state), 2);

        // Charge to full: 98 + 2 saturates at 99
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            run_cycle($urandom_range(0, 3), 1'b1, "to_full");
            done = (m_batt == MAXL);
        end
        check_eq("full_batt", int'(battery), 99);
        check_eq("full_flag", int'(full), 1);
        for (int i = 0; i < 8; i++) run_cycle(1, 1'b1, "hold_full");

        // Battery 1 on gear 1, charger rising on the tick cycle
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (m_mode == MODE_RUN && m_batt == 1 && m_fan == 1 && m_cnt == TD - 1) begin
                done = 1'b1;
            end else begin
                req = (m_batt > 4) ? 3 : 1;
                run_cycle(req, 1'b0, "to_one");
            end
        end
        check_eq("one_reached", int'(battery), 1);
        run_cycle(1, 1'b1, "tick_chg");
        check_eq("tick_chg_state", int'(charging), 1);
        check_eq("tick_chg_batt", int'(battery), 0);
        check_eq("tick_chg_dep", int'(depleted), 0);
        run_cycle(1, 1'b0, "unplug0");
        check_eq("unplug0_dep", int'(depleted), 1);
        check_eq("unplug0_fan", int'(fan_state), 0);

        // Random traffic with an asynchronous reset in the middle
        chg = 1'b0;
        req = 0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) chg = ~chg;
            if ($urandom_range(0, 3) == 0) req = $urandom_range(0, 3);
            run_cycle(req, chg, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
